// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the sequential binary-to-BCD converter.
//   W_BIN    : binary input width (10 bits, values 0..1023)
//   N_DIG    : number of BCD digits produced (4)
//   W_BCD    : width of the BCD scratch / digit bundle (16 bits)
//   CNT_W    : iteration counter width
//   CNT_LAST : counter value of the final (10th) iteration
//   state_e  : converter FSM states (IDLE, CONV)
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int W_BIN = 10;
    localparam int N_DIG = 4;
    localparam int W_BCD = 16;
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

endpackage : bcd_pkg

// File: rtl/bin_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Handshake and result bundle of the binary-to-BCD converter.
//   start : conversion request (master -> slave)
//   bin   : 10-bit binary value, captured when start is accepted
//   busy  : conversion in progress (slave -> master)
//   done  : one-cycle pulse when new digits are valid
//   bcd_t / bcd_h / bcd_d / bcd_u : thousands, hundreds, tens, units digits
// The master modport is the requester (e.g. testbench or display control),
// the slave modport is the converter.
// ---------------------------------------------------------------------------
interface bin_to_bcd_seq_if;
    import bcd_pkg::*;

    logic             start;
    logic [W_BIN-1:0] bin;
    logic             busy;
    logic             done;
    logic [3:0]       bcd_t;
    logic [3:0]       bcd_h;
    logic [3:0]       bcd_d;
    logic [3:0]       bcd_u;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd_t,
        input  bcd_h,
        input  bcd_d,
        input  bcd_u
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd_t,
        output bcd_h,
        output bcd_d,
        output bcd_u
    );

endinterface : bin_to_bcd_seq_if

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
//   din  : 4-bit nibble before correction
//   dout : corrected nibble (din + 3 if din >= 5, else din)
// Inputs never exceed 9 during a conversion, so the result stays <= 12 and
// fits in 4 bits.
// ---------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Purely combinational correction; used once per digit per iteration.
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble converter: 10-bit unsigned binary to four BCD
// digits, one shift/correct iteration per clock, 10 iterations per value.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bin_to_bcd_seq_if.slave (start/bin in, busy/done/digits out)
// Timing: start accepted at edge N -> busy after N .. N+10, digits update
// and done pulses after edge N+10. A held start gives one result every 11
// cycles. Digit outputs only change on completion (never partial values).
// Optional build macro:
//   BIN2BCD_RESTART_EN : start during CONV restarts the conversion with the
//                        newly presented bin; otherwise it is ignored.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
    import bcd_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    bin_to_bcd_seq_if.slave     bus
);

    state_e           state_q,   state_d;
    logic [W_BIN-1:0] shift_q,   shift_d;
    logic [W_BCD-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [W_BCD-1:0] digits_q,  digits_d;

    logic [W_BCD-1:0]       scratch_adj;
    logic [W_BCD+W_BIN-1:0] shifted;
    logic                   restart_req;

    // Correct every scratch nibble before the shift; the thousands nibble
    // is included for uniformity even though it never reaches 5.
    for (genvar g = 0; g < N_DIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[4*g +: 4]),
            .dout (scratch_adj[4*g +: 4])
        );
    end

    // One double-dabble step: the binary MSB moves into the scratch LSB.
    assign shifted = {scratch_adj, shift_q} << 1;

`ifdef BIN2BCD_RESTART_EN
    assign restart_req = bus.start;
`else
    assign restart_req = 1'b0;
`endif

    // Next-state logic: capture on start in IDLE, iterate in CONV, and
    // publish the finished scratch only on the last iteration so the
    // outputs never show a partially converted value.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        digits_d  = digits_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end
            end

            CONV: begin
                if (restart_req) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                end else begin
                    shift_d   = shifted[W_BIN-1:0];
                    scratch_d = shifted[W_BCD+W_BIN-1:W_BIN];
                    if (cnt_q == CNT_LAST) begin
                        digits_d = shifted[W_BCD+W_BIN-1:W_BIN];
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset clears the previous
    // result as well so a reset mid-conversion leaves all digits at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            digits_q  <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            digits_q  <= digits_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.bcd_t = digits_q[15:12];
    assign bus.bcd_h = digits_q[11:8];
    assign bus.bcd_d = digits_q[7:4];
    assign bus.bcd_u = digits_q[3:0];

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq. A behavioural model (countdown of
// remaining cycles plus decimal arithmetic for the digits) predicts busy,
// done and the digit outputs every cycle; directed scenarios add literal
// expectations that pin the model. Honours BIN2BCD_RESTART_EN like the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst_n;

    bin_to_bcd_seq_if bus ();

    bin_to_bcd_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef BIN2BCD_RESTART_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
`endif

    int total;
    int bad;
    int cyc;

    // Behavioural model state
    logic        m_busy;
    logic        m_done;
    logic [15:0] m_dig;
    int          m_left;
    int          m_val;

    // 10 ns clock and a free-running cycle counter for latency measurements.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Decimal digits of a value by plain arithmetic.
    function automatic logic [15:0] digitsOf(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One comparison: counts it, reports a FAIL line on a mismatch.
    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a conversion is pending for 10 edges after acceptance; the
    // result is the decimal expansion of the captured value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dig  <= '0;
            m_left <= 0;
            m_val  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (RESTART_EN && bus.start) begin
                    m_val  <= int'(bus.bin);
                    m_left <= 10;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_dig  <= digitsOf(m_val);
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (bus.start) begin
                m_busy <= 1'b1;
                m_val  <= int'(bus.bin);
                m_left <= 10;
            end
        end
    end

    // Every-cycle compare of the DUT against the model, on the falling edge.
    always @(negedge clk) begin
        checkOutput("busy",   {15'd0, bus.busy}, {15'd0, m_busy});
        checkOutput("done",   {15'd0, bus.done}, {15'd0, m_done});
        checkOutput("digits", {bus.bcd_t, bus.bcd_h, bus.bcd_d, bus.bcd_u}, m_dig);
    end

    // Pulse start for one cycle with the given value.
    task automatic applyStimulus(input int v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 10'(v);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait for done with a bound; reports elapsed negedges and busy cycles.
    task automatic waitDone(output int n, output int b);
        n = 0;
        b = 0;
        while (!bus.done && n < 60) begin
            if (bus.busy) b++;
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    // Full conversion with a literal digit expectation and latency check.
    task automatic convertAndCheck(input int v, input logic [15:0] exp, input string name);
        int n;
        int b;
        applyStimulus(v);
        waitDone(n, b);
        checkOutput({name, "_dut"},     {bus.bcd_t, bus.bcd_h, bus.bcd_d, bus.bcd_u}, exp);
        checkOutput({name, "_model"},   m_dig, exp);
        checkOutput({name, "_latency"}, 16'(n), 16'd10);
        checkOutput({name, "_busycyc"}, 16'(b), 16'd10);
    endtask

    initial begin
        int n;
        int b;
        int t_done [3];
        int p;
        int k;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy",   {15'd0, bus.busy}, 16'd0);
        checkOutput("reset_done",   {15'd0, bus.done}, 16'd0);
        checkOutput("reset_digits", {bus.bcd_t, bus.bcd_h, bus.bcd_d, bus.bcd_u}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values including both range ends.
        convertAndCheck(9,    16'h0009, "bin9");
        convertAndCheck(99,   16'h0099, "bin99");
        convertAndCheck(999,  16'h0999, "bin999");
        convertAndCheck(1023, 16'h1023, "bin1023");
        convertAndCheck(0,    16'h0000, "bin0");

        // bin toggled during the conversion must not matter.
        applyStimulus(345);
        repeat (5) begin
            @(negedge clk);
            bus.bin = 10'($urandom_range(0, 1023));
        end
        waitDone(n, b);
        checkOutput("toggle_bin", {bus.bcd_t, bus.bcd_h, bus.bcd_d, bus.bcd_u}, 16'h0345);

        // Held start: back-to-back conversions every 11 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 10'd512;
        p = 0;
        k = 0;
        while (p < 3 && k < 60) begin
            @(negedge clk);
            k++;
            if (bus.done) begin
                t_done[p] = cyc;
                checkOutput("held_digits", {bus.bcd_t, bus.bcd_h, bus.bcd_d, bus.bcd_u}, 16'h0512);
                p++;
            end
        end
        bus.start = 1'b0;
        checkOutput("held_pulses", 16'(p), 16'd3);
        if (p == 3) begin
            checkOutput("held_period1", 16'(t_done[1] - t_done[0]), 16'd11);
            checkOutput("held_period2", 16'(t_done[2] - t_done[1]), 16'd11);
        end
        repeat (3) @(negedge clk);

        // Reset in the middle of a conversion of 1023.
        applyStimulus(1023);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy",   {15'd0, bus.busy}, 16'd0);
        checkOutput("midrst_done",   {15'd0, bus.done}, 16'd0);
        checkOutput("midrst_digits", {bus.bcd_t, bus.bcd_h, bus.bcd_d, bus.bcd_u}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convertAndCheck(1023, 16'h1023, "after_rst");

        // Second start (42) four cycles into a conversion of 777.
        applyStimulus(777);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 10'd42;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(n, b);
        if (RESTART_EN) begin
            checkOutput("restart_digits",  {bus.bcd_t, bus.bcd_h, bus.bcd_d, bus.bcd_u}, 16'h0042);
            checkOutput("restart_latency", 16'(n), 16'd10);
        end else begin
            checkOutput("ignore_digits",  {bus.bcd_t, bus.bcd_h, bus.bcd_d, bus.bcd_u}, 16'h0777);
            checkOutput("ignore_latency", 16'(n), 16'd6);
        end
        repeat (3) @(negedge clk);

        // Random start pulses and values, checked every cycle by the model.
        repeat (400) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.bin   = 10'($urandom_range(0, 1023));
        end
        bus.start = 1'b0;
        repeat (15) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
